vx_ag_tcu_uop_dispatch: RTL and testbench
=========================================

Name: vx_ag_tcu_uop_dispatch

Overview:
Decode-to-ibuffer stage that expands AG-TCU macro-instructions into micro-ops. It accepts decoded instructions over valid/ready. Plain instructions go through a one-entry output register. AG-TCU instructions are held, and the external uop sequencer is driven with start/next/done, emitting one sequencer uop per output handshake until the last uop has been sent.

Parameters:
DATA_W, 128, width of the ibuffer_t packet carried on all data ports
PERF_W, 32, width of the issued-uop performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction valid
in_data  in  DATA_W  decoded instruction packet
in_is_uop  in  1  instruction is an AG-TCU macro-op needing expansion
in_ready  out  1  stage can accept in_data this cycle
out_valid  out  1  packet valid toward ibuffer
out_data  out  DATA_W  packet toward ibuffer
out_ready  in  1  ibuffer accepts
seq_ibuf_in  out  DATA_W  held macro-instruction fed to the sequencer
seq_start  out  1  one-cycle start pulse to the sequencer
seq_next  out  1  advance sequencer to next uop
seq_done  in  1  sequencer is presenting its last uop
seq_ibuf_out  in  DATA_W  current uop from the sequencer
busy  out  1  expansion in progress
perf_uops  out  PERF_W  total uops issued since reset

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Handshakes are defined as in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
- Reset state: state=IDLE; pass register empty; out_valid=0; in_ready=0 during reset; seq_start=0; seq_next=0; busy=0; perf_uops=0; hold register=0.
- FSM states are IDLE, START and UOP.
- IDLE:
  - in_ready = ~pass_valid | out_ready.
  - Plain in_fire (in_is_uop=0): in_data loads the pass register, pass_valid=1. Latency is 1 cycle.
  - Uop in_fire (in_is_uop=1): in_data loads the hold register, seq_start=1 in the same cycle (combinational from in_fire), and the next state is START.
  - Uop acceptance also requires pass_valid=0 or out_fire this cycle. Otherwise in_ready=0 for a uop-flagged input. Plain instructions are unaffected.
  - out_valid = pass_valid and out_data = pass register.
- START (one cycle; sequencer sets busy and done at this edge):
  - in_ready=0.
  - out_valid = pass_valid, draining the last plain packet if one is still pending.
  - If pass_valid=1 and out_fire=0, the state stays START.
  - Otherwise the next state is UOP and pass_valid is cleared on out_fire.
- UOP:
  - in_ready=0; out_valid=1; out_data = seq_ibuf_out; seq_next = out_ready.
  - On out_fire with seq_done=1, the next state is IDLE.
  - seq_next is still asserted on that cycle so the sequencer clears its busy flag.
- busy = (state != IDLE).
- seq_ibuf_in = hold register. It is constant from the cycle after the uop in_fire until the state returns to IDLE.
- perf_uops increments by 1 on every out_fire in UOP and wraps modulo 2^PERF_W. Plain packets do not count.
- Back-to-back: a new instruction may be accepted in the first IDLE cycle after UOP exits. There is no bubble beyond the START cycle.
- out_valid, once raised, is never dropped and out_data never changes until out_fire.
- Single-uop macro-op: seq_done=1 on the first UOP cycle. Exactly one uop is issued.
- seq_start is never asserted outside IDLE.
- seq_next is never asserted outside UOP.
- Reset mid-expansion aborts immediately:
  - the held instruction is discarded;
  - no further seq_next pulses are issued;
  - the sequencer is reset by the same signal.

Test Plan:
- Plain stream, out_ready=1: 4 plain packets on consecutive cycles -> appear on out_data 1 cycle later, one per cycle, in order; perf_uops=0.
- Uop with a 4-uop sequencer, out_ready=1:
  - uop in_fire at cycle t -> seq_start=1 at t;
  - out_valid=1 at t+2..t+5 carrying seq uops 0..3;
  - seq_next=1 at each of those cycles, seq_done at t+5;
  - IDLE at t+6; perf_uops=4.
- Backpressure: same 4-uop op with out_ready toggling 1,0,1,0,… -> out_data stable while out_ready=0; exactly 4 out_fires; seq_next count=4.
- Pending plain packet with out_ready=0, then a uop arrives -> in_ready=0 for the uop until the plain packet fires; plain packet is emitted before uop 0.
- Single-uop op (seq_done on the first UOP cycle) -> exactly one uop emitted; next plain instruction accepted the cycle after.
- reset asserted in UOP after 2 of 4 uops -> next cycle: out_valid=0, busy=0, perf_uops=0; a following plain instruction passes normally.

Source files
------------

// File: rtl/vx_ag_tcu_uop_dispatch_if.sv
// Interface for the decode-to-ibuffer uop dispatch stage.
//
// Groups the three buses around vx_ag_tcu_uop_dispatch:
//   in_*   : decoded instruction stream (valid/ready) from decode
//   out_*  : packet stream (valid/ready) toward the ibuffer
//   seq_*  : control and data exchanged with the external uop sequencer
//   busy, perf_uops : status outputs of the stage
//
// Modports:
//   slave  : view taken by the dispatch stage itself
//   master : view taken by the surrounding environment (decode, ibuffer, sequencer)
interface vx_ag_tcu_uop_dispatch_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned PERF_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_is_uop;
    logic              in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic [DATA_W-1:0] seq_ibuf_in;
    logic              seq_start;
    logic              seq_next;
    logic              seq_done;
    logic [DATA_W-1:0] seq_ibuf_out;

    logic              busy;
    logic [PERF_W-1:0] perf_uops;

    modport slave (
        input  in_valid, in_data, in_is_uop, out_ready, seq_done, seq_ibuf_out,
        output in_ready, out_valid, out_data, seq_ibuf_in, seq_start, seq_next,
               busy, perf_uops
    );

    modport master (
        output in_valid, in_data, in_is_uop, out_ready, seq_done, seq_ibuf_out,
        input  in_ready, out_valid, out_data, seq_ibuf_in, seq_start, seq_next,
               busy, perf_uops
    );

endinterface

// File: rtl/vx_ag_tcu_uop_dispatch.sv
// Decode-to-ibuffer stage expanding AG-TCU macro-instructions into micro-ops.
//
// Plain instructions pass through a one-entry output register (1 cycle latency).
// AG-TCU macro-ops are captured in a hold register, the external sequencer is
// kicked with seq_start, and its uops are forwarded one per output handshake,
// with seq_next advancing the sequencer, until the uop flagged by seq_done is sent.
//
// Ports:
//   clk          : clock
//   reset        : synchronous active-high reset (also resets the sequencer externally)
//   dispatch_io  : slave view of vx_ag_tcu_uop_dispatch_if
//                  (in_* decode stream, out_* ibuffer stream, seq_* sequencer link,
//                   busy and perf_uops status)
module vx_ag_tcu_uop_dispatch #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned PERF_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_ag_tcu_uop_dispatch_if.slave dispatch_io
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StUop
    } state_e;

    state_e            state_q, state_d;
    logic              pass_valid_q, pass_valid_d;
    logic [DATA_W-1:0] pass_data_q, pass_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              seq_start;
    logic              seq_next;
    logic              in_fire;
    logic              out_fire;

    always_comb begin
        state_d      = state_q;
        pass_valid_d = pass_valid_q;
        pass_data_d  = pass_data_q;
        hold_d       = hold_q;
        perf_d       = perf_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = pass_data_q;
        seq_start    = 1'b0;
        seq_next     = 1'b0;

        // Handshake-side outputs per state.
        unique case (state_q)
            StIdle: begin
                // ~pass_valid | out_ready equals "pass empty or draining this cycle",
                // which is exactly the extra condition a uop-flagged input needs.
                in_ready  = ~pass_valid_q | dispatch_io.out_ready;
                out_valid = pass_valid_q;
            end
            StStart: begin
                out_valid = pass_valid_q;
            end
            StUop: begin
                out_valid = 1'b1;
                out_data  = dispatch_io.seq_ibuf_out;
                seq_next  = dispatch_io.out_ready;
            end
            default: ;
        endcase

        // Reset aborts at once: no accepts, no output, no sequencer advance.
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            seq_next  = 1'b0;
        end

        in_fire  = dispatch_io.in_valid & in_ready;
        out_fire = out_valid & dispatch_io.out_ready;

        // Next-state and register updates.
        case (state_q)
            StIdle: begin
                if (out_fire) begin
                    pass_valid_d = 1'b0;
                end
                if (in_fire && !dispatch_io.in_is_uop) begin
                    pass_valid_d = 1'b1;
                    pass_data_d  = dispatch_io.in_data;
                end
                if (in_fire && dispatch_io.in_is_uop) begin
                    hold_d    = dispatch_io.in_data;
                    seq_start = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (out_fire) begin
                    pass_valid_d = 1'b0;
                end
                // Wait here while a plain packet is still stuck in the pass register.
                if (!(pass_valid_q && !out_fire)) begin
                    state_d = StUop;
                end
            end
            StUop: begin
                if (out_fire) begin
                    perf_d = perf_q + 1'b1;
                    if (dispatch_io.seq_done) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pass_valid_q <= 1'b0;
            pass_data_q  <= '0;
            hold_q       <= '0;
            perf_q       <= '0;
        end else begin
            state_q      <= state_d;
            pass_valid_q <= pass_valid_d;
            pass_data_q  <= pass_data_d;
            hold_q       <= hold_d;
            perf_q       <= perf_d;
        end
    end

    assign dispatch_io.in_ready    = in_ready;
    assign dispatch_io.out_valid   = out_valid;
    assign dispatch_io.out_data    = out_data;
    assign dispatch_io.seq_ibuf_in = hold_q;
    assign dispatch_io.seq_start   = seq_start;
    assign dispatch_io.seq_next    = seq_next;
    assign dispatch_io.busy        = (state_q != StIdle);
    assign dispatch_io.perf_uops   = perf_q;

endmodule

// File: tb/tb_vx_ag_tcu_uop_dispatch.sv
// Directed testbench for vx_ag_tcu_uop_dispatch.
// A small behavioural sequencer stub produces uop k of a macro-op as
// (macro + k + 1); expected values below are written out by hand.
module tb_vx_ag_tcu_uop_dispatch;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned PERF_W = 32;

    logic clk;
    logic reset;

    vx_ag_tcu_uop_dispatch_if #(.DATA_W(DATA_W), .PERF_W(PERF_W)) dif ();

    vx_ag_tcu_uop_dispatch #(.DATA_W(DATA_W), .PERF_W(PERF_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .dispatch_io (dif.slave)
    );

    int checks;
    int passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequencer stub: started by seq_start, advanced by seq_next, reset by reset.
    int unsigned seq_len;
    logic        seq_active;
    int unsigned seq_cnt;

    always @(posedge clk) begin
        if (reset) begin
            seq_active <= 1'b0;
            seq_cnt    <= 0;
        end else if (dif.seq_start) begin
            seq_active <= 1'b1;
            seq_cnt    <= 0;
        end else if (dif.seq_next && seq_active) begin
            if (seq_cnt == seq_len - 1) seq_active <= 1'b0;
            else seq_cnt <= seq_cnt + 1;
        end
    end

    assign dif.seq_done     = seq_active && (seq_cnt == seq_len - 1);
    assign dif.seq_ibuf_out = seq_active ? dif.seq_ibuf_in + 128'(seq_cnt + 1) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b0;
        dif.in_data   = 128'hDEAD;
        dif.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (dif.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", dif.in_ready); else passed++;
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", dif.out_valid); else passed++;
        checks++; if (dif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", dif.busy); else passed++;
        checks++; if (dif.seq_start !== 1'b0) $display("FAIL rst_seq_start: got %b want 0", dif.seq_start); else passed++;
        checks++; if (dif.seq_next !== 1'b0) $display("FAIL rst_seq_next: got %b want 0", dif.seq_next); else passed++;
        checks++; if (dif.perf_uops !== 32'd0) $display("FAIL rst_perf: got %0d want 0", dif.perf_uops); else passed++;
        checks++; if (dif.seq_ibuf_in !== 128'd0) $display("FAIL rst_hold: got %h want 0", dif.seq_ibuf_in); else passed++;
        tick();
        reset        = 1'b0;
        dif.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_plain_stream();
        logic [DATA_W-1:0] d [4];
        d[0] = 128'h11; d[1] = 128'h22; d[2] = 128'h33; d[3] = 128'h44;
        dif.out_ready = 1'b1;
        dif.in_is_uop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dif.in_valid = (k < 4);
            dif.in_data  = (k < 4) ? d[k] : '0;
            @(negedge clk);
            if (k < 4) begin
                checks++; if (dif.in_ready !== 1'b1) $display("FAIL plain_in_ready[%0d]: got %b want 1", k, dif.in_ready); else passed++;
            end
            if (k >= 1) begin
                checks++;
                if (dif.out_valid !== 1'b1 || dif.out_data !== d[k-1])
                    $display("FAIL plain_out[%0d]: got v=%b %h want v=1 %h", k, dif.out_valid, dif.out_data, d[k-1]);
                else passed++;
            end
            tick();
        end
        @(negedge clk);
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL plain_drain: got %b want 0", dif.out_valid); else passed++;
        checks++; if (dif.perf_uops !== 32'd0) $display("FAIL plain_perf: got %0d want 0", dif.perf_uops); else passed++;
        tick();
    endtask

    task automatic test_uop_four();
        seq_len       = 4;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b1;
        dif.in_data   = 128'h1000;
        @(negedge clk);  // cycle t
        checks++; if (dif.in_ready !== 1'b1) $display("FAIL uop4_in_ready: got %b want 1", dif.in_ready); else passed++;
        checks++; if (dif.seq_start !== 1'b1) $display("FAIL uop4_seq_start: got %b want 1", dif.seq_start); else passed++;
        tick();
        dif.in_valid = 1'b0;
        @(negedge clk);  // t+1, START
        checks++; if (dif.busy !== 1'b1) $display("FAIL uop4_start_busy: got %b want 1", dif.busy); else passed++;
        checks++; if (dif.out_valid !== 1'b0 || dif.seq_next !== 1'b0 || dif.seq_start !== 1'b0)
            $display("FAIL uop4_start_quiet: got v=%b nx=%b st=%b want 0 0 0", dif.out_valid, dif.seq_next, dif.seq_start);
        else passed++;
        checks++; if (dif.seq_ibuf_in !== 128'h1000) $display("FAIL uop4_hold: got %h want 1000", dif.seq_ibuf_in); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin  // t+2 .. t+5
            @(negedge clk);
            checks++;
            if (dif.out_valid !== 1'b1 || dif.out_data !== 128'h1001 + 128'(k) || dif.seq_next !== 1'b1 ||
                dif.seq_done !== (k == 3))
                $display("FAIL uop4_uop[%0d]: got v=%b %h nx=%b dn=%b want v=1 %h nx=1 dn=%b", k, dif.out_valid,
                         dif.out_data, dif.seq_next, dif.seq_done, 128'h1001 + 128'(k), (k == 3));
            else passed++;
            tick();
        end
        @(negedge clk);  // t+6
        checks++; if (dif.busy !== 1'b0) $display("FAIL uop4_idle: got busy=%b want 0", dif.busy); else passed++;
        checks++; if (dif.perf_uops !== 32'd4) $display("FAIL uop4_perf: got %0d want 4", dif.perf_uops); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int fires = 0;
        int nexts = 0;
        logic [DATA_W-1:0] saved = '0;
        seq_len       = 4;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b1;
        dif.in_data   = 128'h2000;
        tick();
        dif.in_valid = 1'b0;
        tick();  // START
        for (int i = 0; i < 20; i++) begin
            dif.out_ready = (i % 2 == 0);
            @(negedge clk);
            if (!dif.busy) break;
            if (i > 0 && i % 2 == 0) begin
                checks++; if (dif.out_data !== saved) $display("FAIL bp_stable[%0d]: got %h want %h", i, dif.out_data, saved); else passed++;
            end
            if (dif.out_valid && dif.out_ready) begin
                checks++;
                if (dif.out_data !== 128'h2001 + 128'(fires))
                    $display("FAIL bp_data[%0d]: got %h want %h", fires, dif.out_data, 128'h2001 + 128'(fires));
                else passed++;
                fires++;
            end else begin
                saved = dif.out_data;
            end
            if (dif.seq_next) nexts++;
            tick();
        end
        checks++; if (fires != 4) $display("FAIL bp_fires: got %0d want 4", fires); else passed++;
        checks++; if (nexts != 4) $display("FAIL bp_nexts: got %0d want 4", nexts); else passed++;
        checks++; if (dif.perf_uops !== 32'd8) $display("FAIL bp_perf: got %0d want 8", dif.perf_uops); else passed++;
        dif.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_pending_plain();
        seq_len       = 2;
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b0;
        dif.in_data   = 128'h3333;
        @(negedge clk);
        checks++; if (dif.in_ready !== 1'b1) $display("FAIL pend_plain_acc: got %b want 1", dif.in_ready); else passed++;
        tick();
        dif.in_is_uop = 1'b1;
        dif.in_data   = 128'h4000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1 || dif.out_data !== 128'h3333)
                $display("FAIL pend_block[%0d]: got rdy=%b v=%b %h want 0 1 3333", k, dif.in_ready, dif.out_valid, dif.out_data);
            else passed++;
            tick();
        end
        dif.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.in_ready !== 1'b1 || dif.seq_start !== 1'b1 || dif.out_data !== 128'h3333)
            $display("FAIL pend_release: got rdy=%b st=%b %h want 1 1 3333", dif.in_ready, dif.seq_start, dif.out_data);
        else passed++;
        tick();
        dif.in_valid = 1'b0;
        @(negedge clk);  // START
        checks++; if (dif.out_valid !== 1'b0) $display("FAIL pend_start: got v=%b want 0", dif.out_valid); else passed++;
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (dif.out_valid !== 1'b1 || dif.out_data !== 128'h4001 + 128'(k))
                $display("FAIL pend_uop[%0d]: got v=%b %h want 1 %h", k, dif.out_valid, dif.out_data, 128'h4001 + 128'(k));
            else passed++;
            tick();
        end
        @(negedge clk);
        checks++; if (dif.busy !== 1'b0 || dif.perf_uops !== 32'd10)
            $display("FAIL pend_end: got busy=%b perf=%0d want 0 10", dif.busy, dif.perf_uops);
        else passed++;
        tick();
    endtask

    task automatic test_single_uop();
        seq_len       = 1;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b1;
        dif.in_data   = 128'h5000;
        tick();
        dif.in_valid = 1'b0;
        tick();  // START
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_data !== 128'h5001 || dif.seq_done !== 1'b1 || dif.seq_next !== 1'b1)
            $display("FAIL single_uop: got v=%b %h dn=%b nx=%b want 1 5001 1 1", dif.out_valid, dif.out_data,
                     dif.seq_done, dif.seq_next);
        else passed++;
        tick();
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b0;
        dif.in_data   = 128'h6666;
        @(negedge clk);
        checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0)
            $display("FAIL single_next_acc: got rdy=%b busy=%b want 1 0", dif.in_ready, dif.busy);
        else passed++;
        tick();
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_data !== 128'h6666)
            $display("FAIL single_next_out: got v=%b %h want 1 6666", dif.out_valid, dif.out_data);
        else passed++;
        checks++; if (dif.perf_uops !== 32'd11) $display("FAIL single_perf: got %0d want 11", dif.perf_uops); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        seq_len       = 4;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b1;
        dif.in_data   = 128'h7000;
        tick();
        dif.in_valid = 1'b0;
        tick();  // START
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (dif.out_data !== 128'h7001 + 128'(k))
                $display("FAIL rmid_uop[%0d]: got %h want %h", k, dif.out_data, 128'h7001 + 128'(k));
            else passed++;
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dif.seq_next !== 1'b0) $display("FAIL rmid_no_next: got %b want 0", dif.seq_next); else passed++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b0 || dif.busy !== 1'b0 || dif.perf_uops !== 32'd0 || dif.seq_ibuf_in !== 128'd0)
            $display("FAIL rmid_after: got v=%b busy=%b perf=%0d hold=%h want 0 0 0 0", dif.out_valid, dif.busy,
                     dif.perf_uops, dif.seq_ibuf_in);
        else passed++;
        dif.in_valid  = 1'b1;
        dif.in_is_uop = 1'b0;
        dif.in_data   = 128'h8888;
        @(negedge clk);
        checks++; if (dif.in_ready !== 1'b1) $display("FAIL rmid_plain_acc: got %b want 1", dif.in_ready); else passed++;
        tick();
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (dif.out_valid !== 1'b1 || dif.out_data !== 128'h8888 || dif.perf_uops !== 32'd0)
            $display("FAIL rmid_plain_out: got v=%b %h perf=%0d want 1 8888 0", dif.out_valid, dif.out_data, dif.perf_uops);
        else passed++;
        tick();
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        seq_len       = 4;
        reset         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.in_is_uop = 1'b0;
        dif.out_ready = 1'b0;
        test_reset();
        test_plain_stream();
        test_uop_four();
        test_backpressure();
        test_pending_plain();
        test_single_uop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
